// File: rtl/pim_ctrl_seq.sv
// PIM sequencer: decodes peripheral-bus accesses into weight/activation/result strobes
// for the PIM macro and tracks row loading, activation loading and compute latency.
module pim_ctrl_seq #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int N_LANES  = 4,
  parameter int W_BEATS  = 16,
  parameter int WL_ROWS  = 288,
  parameter int A_BEATS  = 9,
  parameter int COMP_LAT = 6,
  parameter int R_BEATS  = 2,
  localparam int SEL_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1,
  localparam int WL_W   = (WL_ROWS > 1) ? $clog2(WL_ROWS) : 1,
  localparam int MAX_WA = (W_BEATS > A_BEATS) ? W_BEATS : A_BEATS,
  localparam int MAX_CR = (COMP_LAT > R_BEATS) ? COMP_LAT : R_BEATS,
  localparam int CNT_W  = $clog2(((MAX_WA > MAX_CR) ? MAX_WA : MAX_CR) + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_we,
  input  logic [31:0]      i_address,
  output logic             o_w_we,
  output logic [SEL_W-1:0] o_w_sel,
  output logic             o_w_commit,
  output logic [WL_W-1:0]  o_wl_addr,
  output logic             o_a_we,
  output logic [SEL_W-1:0] o_a_sel,
  output logic             o_compute_start,
  output logic             o_r_capture,
  output logic             o_r_re,
  output logic [CNT_W-1:0] o_r_idx,
  output logic             o_status_rd,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_err,
  output logic [CNT_W-1:0] o_beat_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WLOAD, S_ALOAD, S_COMP} state_t;

  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(W_BEATS);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A_BEATS);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(COMP_LAT);
  localparam logic [CNT_W-1:0] C_PRE  = CNT_W'(COMP_LAT - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(R_BEATS - 1);
  localparam logic [WL_W-1:0]  WL_TOP = WL_W'(WL_ROWS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt, r_ridx;
  logic [WL_W-1:0]  r_wl_addr;
  logic             r_commit, r_start, r_capture, r_status_rd, r_valid, r_err;

  logic [7:0]       w_off;
  logic [5:0]       w_lanes;
  logic [SEL_W-1:0] w_sel;
  logic             w_hit, w_lane_ok, w_wgt, w_act, w_stat, w_res, w_clr;
  logic             w_w_ok, w_a_ok, w_r_ok, w_err_set;
  logic [CNT_W-1:0] w_w_next, w_a_next;

  assign w_off     = i_address[7:0];
  assign w_lanes   = w_off[5:0];
  assign w_hit     = i_valid && (i_address[31:8] == BASE_ADDR[31:8]);
  // Lane must be a single bit and must land inside the configured lane count
  assign w_lane_ok = $onehot(w_lanes) && ((w_lanes >> N_LANES) == 6'd0);
  assign w_wgt     = w_hit &&  i_we && (w_off[7:6] == 2'b01);
  assign w_act     = w_hit &&  i_we && (w_off[7:6] == 2'b10);
  assign w_clr     = w_hit &&  i_we && (w_off == 8'h30);
  assign w_stat    = w_hit && !i_we && (w_off == 8'h10);
  assign w_res     = w_hit && !i_we && (w_off == 8'h20);

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < N_LANES; k++)
      if (w_lanes[k]) w_sel = SEL_W'(k);
  end

  assign w_w_ok = w_wgt && w_lane_ok && (r_state == S_IDLE || r_state == S_WLOAD);
  assign w_a_ok = w_act && w_lane_ok && !r_valid && (r_state != S_COMP);
  assign w_r_ok = w_res && r_valid;

  // An activation landing mid-row is accepted but flags the discarded row
  assign w_err_set = ((w_wgt || w_act) && !w_lane_ok) ||
                     (w_wgt && w_lane_ok && !w_w_ok) ||
                     (w_act && w_lane_ok && !w_a_ok) ||
                     (w_a_ok && r_state == S_WLOAD) ||
                     (w_res && !r_valid);

  assign w_w_next = ((r_state == S_WLOAD) ? r_cnt : '0) + CNT_W'(1);
  assign w_a_next = ((r_state == S_ALOAD) ? r_cnt : '0) + CNT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ridx      <= '0;
      r_wl_addr   <= '0;
      r_commit    <= 1'b0;
      r_start     <= 1'b0;
      r_capture   <= 1'b0;
      r_status_rd <= 1'b0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_commit    <= 1'b0;
      r_start     <= 1'b0;
      r_capture   <= 1'b0;
      r_status_rd <= w_stat;
      if (w_err_set) r_err <= 1'b1;
      // Row address advances after the commit cycle so the commit sees the old row
      if (r_commit) r_wl_addr <= (r_wl_addr == WL_TOP) ? '0 : r_wl_addr + WL_W'(1);
      if (w_clr) begin
        r_err     <= 1'b0;
        r_wl_addr <= '0;
      end
      if (w_r_ok) begin
        if (r_ridx == R_LAST) begin
          r_ridx  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_ridx  <= r_ridx + CNT_W'(1);
        end
      end
      case (r_state)
        S_COMP: begin
          if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == C_PRE) r_capture <= 1'b1;
          end
        end
        default: begin
          if (w_w_ok) begin
            if (w_w_next == W_LAST) begin
              r_commit <= 1'b1;
              r_cnt    <= '0;
              r_state  <= S_IDLE;
            end else begin
              r_cnt    <= w_w_next;
              r_state  <= S_WLOAD;
            end
          end else if (w_a_ok) begin
            if (w_a_next == A_LAST) begin
              r_start  <= 1'b1;
              r_cnt    <= '0;
              r_state  <= S_COMP;
            end else begin
              r_cnt    <= w_a_next;
              r_state  <= S_ALOAD;
            end
          end
        end
      endcase
    end
  end

  assign o_w_we          = w_w_ok;
  assign o_w_sel         = w_w_ok ? w_sel : '0;
  assign o_a_we          = w_a_ok;
  assign o_a_sel         = w_a_ok ? w_sel : '0;
  assign o_r_re          = w_r_ok;
  assign o_r_idx         = w_r_ok ? r_ridx : '0;
  assign o_w_commit      = r_commit;
  assign o_wl_addr       = r_wl_addr;
  assign o_compute_start = r_start;
  assign o_r_capture     = r_capture;
  assign o_status_rd     = r_status_rd;
  assign o_busy          = (r_state != S_IDLE);
  assign o_valid         = r_valid;
  assign o_err           = r_err;
  assign o_beat_cnt      = r_cnt;

endmodule

// File: tb/tb_pim_ctrl_seq.sv
// Directed bench for pim_ctrl_seq: default configuration plus a small configuration
// sharing the same bus stimulus.
module tb_pim_ctrl_seq;

  logic clk, rst_n, s_rst_n, valid, we;
  logic [31:0] addr;

  logic       b_w_we, b_w_commit, b_a_we, b_start, b_cap, b_r_re, b_st, b_busy, b_valid, b_err;
  logic [1:0] b_w_sel, b_a_sel;
  logic [8:0] b_wl;
  logic [4:0] b_r_idx, b_cnt;

  logic       s_w_we, s_w_commit, s_a_we, s_start, s_cap, s_r_re, s_st, s_busy, s_valid, s_err;
  logic [0:0] s_w_sel, s_a_sel;
  logic [1:0] s_wl;
  logic [2:0] s_r_idx, s_cnt;

  int n_chk = 0;
  int n_pass = 0;

  pim_ctrl_seq u_big (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_we(we), .i_address(addr),
    .o_w_we(b_w_we), .o_w_sel(b_w_sel), .o_w_commit(b_w_commit), .o_wl_addr(b_wl),
    .o_a_we(b_a_we), .o_a_sel(b_a_sel), .o_compute_start(b_start), .o_r_capture(b_cap),
    .o_r_re(b_r_re), .o_r_idx(b_r_idx), .o_status_rd(b_st), .o_busy(b_busy),
    .o_valid(b_valid), .o_err(b_err), .o_beat_cnt(b_cnt));

  pim_ctrl_seq #(.N_LANES(2), .W_BEATS(4), .WL_ROWS(3), .A_BEATS(2), .COMP_LAT(1), .R_BEATS(1)) u_small (
    .i_clk(clk), .i_rst_n(s_rst_n), .i_valid(valid), .i_we(we), .i_address(addr),
    .o_w_we(s_w_we), .o_w_sel(s_w_sel), .o_w_commit(s_w_commit), .o_wl_addr(s_wl),
    .o_a_we(s_a_we), .o_a_sel(s_a_sel), .o_compute_start(s_start), .o_r_capture(s_cap),
    .o_r_re(s_r_re), .o_r_idx(s_r_idx), .o_status_rd(s_st), .o_busy(s_busy),
    .o_valid(s_valid), .o_err(s_err), .o_beat_cnt(s_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drv(input logic w, input logic [7:0] off);
    valid = 1'b1; we = w; addr = 32'h4000_0000 | {24'h0, off}; #1;
  endtask

  task automatic nop();
    valid = 1'b0; we = 1'b0; addr = 32'h0; #1;
  endtask

  task automatic write_row();
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 8'h41); cyc();
    end
    nop();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_rst_n = 1'b0; nop(); cyc(); cyc();
    n_chk++; if (b_busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", b_busy); else n_pass++;
    n_chk++; if (b_wl !== 9'd0) $display("FAIL rst_wl got %0d exp 0", b_wl); else n_pass++;
    n_chk++; if ({b_err, b_valid, b_w_commit, b_start, b_cap, b_st} !== 6'b0)
      $display("FAIL rst_flags got %b exp 000000", {b_err, b_valid, b_w_commit, b_start, b_cap, b_st}); else n_pass++;
    n_chk++; if (b_cnt !== 5'd0) $display("FAIL rst_cnt got %0d exp 0", b_cnt); else n_pass++;
    rst_n = 1'b1; cyc();
    for (int i = 0; i < 7; i++) begin
      drv(1'b1, 8'h41); cyc();
    end
    nop();
    n_chk++; if (b_cnt !== 5'd7) $display("FAIL mid_cnt got %0d exp 7", b_cnt); else n_pass++;
    n_chk++; if (b_busy !== 1'b1) $display("FAIL mid_busy got %0b exp 1", b_busy); else n_pass++;
    #2 rst_n = 1'b0; #1;
    n_chk++; if ({b_busy, b_cnt} !== 6'd0) $display("FAIL async_rst got busy=%0b cnt=%0d exp 0/0", b_busy, b_cnt); else n_pass++;
    cyc(); rst_n = 1'b1; cyc();
  endtask

  task automatic test_weight_row();
    for (int i = 0; i < 16; i++) begin
      drv(1'b1, 8'h40 | (8'h1 << (i % 4)));
      n_chk++; if ({b_w_we, b_w_sel} !== {1'b1, 2'(i % 4)})
        $display("FAIL w_sel beat %0d got we=%0b sel=%0d exp 1/%0d", i, b_w_we, b_w_sel, i % 4); else n_pass++;
      cyc();
      if (i < 15) begin
        n_chk++; if ({b_w_commit, b_cnt} !== {1'b0, 5'(i + 1)})
          $display("FAIL w_beat %0d got commit=%0b cnt=%0d exp 0/%0d", i, b_w_commit, b_cnt, i + 1); else n_pass++;
      end
    end
    nop();
    n_chk++; if ({b_w_commit, b_wl, b_busy} !== {1'b1, 9'd0, 1'b0})
      $display("FAIL commit got c=%0b wl=%0d busy=%0b exp 1/0/0", b_w_commit, b_wl, b_busy); else n_pass++;
    cyc();
    n_chk++; if ({b_w_commit, b_wl} !== {1'b0, 9'd1})
      $display("FAIL wl_inc got c=%0b wl=%0d exp 0/1", b_w_commit, b_wl); else n_pass++;
    for (int r = 0; r < 286; r++) write_row();
    cyc();
    n_chk++; if (b_wl !== 9'd287) $display("FAIL wl_287 got %0d exp 287", b_wl); else n_pass++;
    write_row();
    n_chk++; if ({b_w_commit, b_wl} !== {1'b1, 9'd287})
      $display("FAIL wl_last_commit got c=%0b wl=%0d exp 1/287", b_w_commit, b_wl); else n_pass++;
    cyc();
    n_chk++; if (b_wl !== 9'd0) $display("FAIL wl_wrap got %0d exp 0", b_wl); else n_pass++;
  endtask

  task automatic test_compute();
    logic early;
    early = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drv(1'b1, 8'h81);
      if (i == 0) begin
        n_chk++; if ({b_a_we, b_a_sel} !== 3'b100) $display("FAIL a_we got we=%0b sel=%0d exp 1/0", b_a_we, b_a_sel); else n_pass++;
      end
      cyc();
      if (i < 8 && b_start) early = 1'b1;
    end
    nop();
    n_chk++; if ({b_start, b_busy, early} !== 3'b110)
      $display("FAIL start got start=%0b busy=%0b early=%0b exp 1/1/0", b_start, b_busy, early); else n_pass++;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k < 6 && b_cap) early = 1'b1;
    end
    n_chk++; if ({b_cap, early} !== 2'b10) $display("FAIL capture got cap=%0b early=%0b exp 1/0", b_cap, early); else n_pass++;
    cyc();
    n_chk++; if ({b_valid, b_busy, b_cap} !== 3'b100)
      $display("FAIL res_valid got v=%0b busy=%0b cap=%0b exp 1/0/0", b_valid, b_busy, b_cap); else n_pass++;
    drv(1'b0, 8'h20);
    n_chk++; if ({b_r_re, b_r_idx} !== {1'b1, 5'd0}) $display("FAIL rd0 got re=%0b idx=%0d exp 1/0", b_r_re, b_r_idx); else n_pass++;
    cyc();
    n_chk++; if (b_valid !== 1'b1) $display("FAIL rd0_valid got %0b exp 1", b_valid); else n_pass++;
    drv(1'b0, 8'h20);
    n_chk++; if ({b_r_re, b_r_idx} !== {1'b1, 5'd1}) $display("FAIL rd1 got re=%0b idx=%0d exp 1/1", b_r_re, b_r_idx); else n_pass++;
    cyc(); nop();
    n_chk++; if ({b_valid, b_err} !== 2'b00) $display("FAIL rd_done got v=%0b err=%0b exp 0/0", b_valid, b_err); else n_pass++;
  endtask

  task automatic test_errors();
    drv(1'b0, 8'h20);
    n_chk++; if ({b_r_re, b_r_idx} !== 6'd0) $display("FAIL rd_empty got re=%0b idx=%0d exp 0/0", b_r_re, b_r_idx); else n_pass++;
    cyc(); nop();
    n_chk++; if (b_err !== 1'b1) $display("FAIL rd_empty_err got %0b exp 1", b_err); else n_pass++;
    drv(1'b1, 8'h30); cyc(); nop();
    n_chk++; if (b_err !== 1'b0) $display("FAIL clear got %0b exp 0", b_err); else n_pass++;
    drv(1'b1, 8'h43);
    n_chk++; if (b_w_we !== 1'b0) $display("FAIL bad_lane_we got %0b exp 0", b_w_we); else n_pass++;
    cyc(); nop();
    n_chk++; if ({b_err, b_busy} !== 2'b10) $display("FAIL bad_lane got err=%0b busy=%0b exp 1/0", b_err, b_busy); else n_pass++;
    drv(1'b1, 8'h30); cyc(); nop();
    n_chk++; if (b_err !== 1'b0) $display("FAIL clear2 got %0b exp 0", b_err); else n_pass++;
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 8'h41); cyc();
    end
    drv(1'b1, 8'h82);
    n_chk++; if ({b_a_we, b_a_sel} !== 3'b101) $display("FAIL abort_a got we=%0b sel=%0d exp 1/1", b_a_we, b_a_sel); else n_pass++;
    cyc(); nop();
    n_chk++; if ({b_err, b_busy, b_w_commit, b_cnt} !== {3'b110, 5'd1})
      $display("FAIL abort got err=%0b busy=%0b c=%0b cnt=%0d exp 1/1/0/1", b_err, b_busy, b_w_commit, b_cnt); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 8'h81); cyc();
    end
    nop();
    n_chk++; if (b_start !== 1'b1) $display("FAIL abort_start got %0b exp 1", b_start); else n_pass++;
    drv(1'b1, 8'h81);
    n_chk++; if (b_a_we !== 1'b0) $display("FAIL comp_act got %0b exp 0", b_a_we); else n_pass++;
    drv(1'b1, 8'h41);
    n_chk++; if (b_w_we !== 1'b0) $display("FAIL comp_wgt got %0b exp 0", b_w_we); else n_pass++;
    cyc(); nop();
    repeat (6) cyc();
    n_chk++; if ({b_valid, b_wl} !== {1'b1, 9'd0}) $display("FAIL abort_valid got v=%0b wl=%0d exp 1/0", b_valid, b_wl); else n_pass++;
    drv(1'b0, 8'h20); cyc(); drv(1'b0, 8'h20); cyc();
    drv(1'b1, 8'h30); cyc(); nop();
    n_chk++; if ({b_valid, b_err} !== 2'b00) $display("FAIL abort_end got v=%0b err=%0b exp 0/0", b_valid, b_err); else n_pass++;
  endtask

  task automatic test_clear_commit();
    write_row();
    drv(1'b1, 8'h30);
    n_chk++; if (b_w_commit !== 1'b1) $display("FAIL cc_commit got %0b exp 1", b_w_commit); else n_pass++;
    cyc(); nop();
    n_chk++; if ({b_wl, b_w_commit} !== 10'd0) $display("FAIL cc_wl got wl=%0d c=%0b exp 0/0", b_wl, b_w_commit); else n_pass++;
  endtask

  task automatic test_status();
    drv(1'b0, 8'h10);
    n_chk++; if (b_st !== 1'b0) $display("FAIL st_early got %0b exp 0", b_st); else n_pass++;
    cyc(); nop();
    n_chk++; if (b_st !== 1'b1) $display("FAIL st_pulse got %0b exp 1", b_st); else n_pass++;
    cyc();
    n_chk++; if (b_st !== 1'b0) $display("FAIL st_end got %0b exp 0", b_st); else n_pass++;
    drv(1'b0, 8'h50); cyc(); nop();
    n_chk++; if ({b_st, b_err} !== 2'b00) $display("FAIL unmapped got st=%0b err=%0b exp 0/0", b_st, b_err); else n_pass++;
  endtask

  task automatic test_small();
    s_rst_n = 1'b1; cyc();
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 4; b++) begin
        drv(1'b1, (b % 2) ? 8'h42 : 8'h41); cyc();
      end
      nop();
      n_chk++; if ({s_w_commit, s_wl} !== {1'b1, 2'(r % 3)})
        $display("FAIL sm_row %0d got c=%0b wl=%0d exp 1/%0d", r, s_w_commit, s_wl, r % 3); else n_pass++;
    end
    cyc();
    drv(1'b1, 8'h44);
    n_chk++; if (s_w_we !== 1'b0) $display("FAIL sm_lane_we got %0b exp 0", s_w_we); else n_pass++;
    cyc(); nop();
    n_chk++; if (s_err !== 1'b1) $display("FAIL sm_lane_err got %0b exp 1", s_err); else n_pass++;
    drv(1'b1, 8'h30); cyc();
    drv(1'b1, 8'h82);
    n_chk++; if ({s_a_we, s_a_sel} !== 2'b11) $display("FAIL sm_a got we=%0b sel=%0d exp 1/1", s_a_we, s_a_sel); else n_pass++;
    cyc(); drv(1'b1, 8'h81); cyc(); nop();
    n_chk++; if ({s_start, s_cap} !== 2'b10) $display("FAIL sm_start got s=%0b cap=%0b exp 1/0", s_start, s_cap); else n_pass++;
    cyc();
    n_chk++; if ({s_start, s_cap} !== 2'b01) $display("FAIL sm_cap got s=%0b cap=%0b exp 0/1", s_start, s_cap); else n_pass++;
    cyc();
    n_chk++; if ({s_valid, s_busy} !== 2'b10) $display("FAIL sm_valid got v=%0b busy=%0b exp 1/0", s_valid, s_busy); else n_pass++;
    drv(1'b0, 8'h20);
    n_chk++; if ({s_r_re, s_r_idx} !== 4'b1000) $display("FAIL sm_rd got re=%0b idx=%0d exp 1/0", s_r_re, s_r_idx); else n_pass++;
    cyc(); nop();
    n_chk++; if ({s_valid, s_err} !== 2'b00) $display("FAIL sm_rd_done got v=%0b err=%0b exp 0/0", s_valid, s_err); else n_pass++;
  endtask

  initial begin
    valid = 1'b0; we = 1'b0; addr = 32'h0; rst_n = 1'b0; s_rst_n = 1'b0;
    test_reset();
    test_weight_row();
    test_compute();
    test_errors();
    test_abort();
    test_clear_commit();
    test_status();
    test_small();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
